dfp_arbiter: RTL and testbench

Shares one 256-bit cacheline memory port between `NUM_REQ` cache instances (requester 0 = instruction cache, requester 1 = data cache). Each requester drives the standard `dfp_*` downward-facing port of a cache. The arbiter grants one requester at a time, latches its request and holds the memory port until `mem_resp`. It sits between the cache `dfp_*` ports and the memory model or bus adapter.

---
 rtl/dfp_arbiter.sv | 147 ++++++++++++++
 tb/tb_dfp_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfp_arbiter.sv
// Shares one cacheline memory port among NUM_REQ cache dfp_* ports; one transaction in flight at a time.
// Define DFP_ARB_RR_EN for round-robin priority; otherwise the lowest requester index wins.
module dfp_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         req_addr  [NUM_REQ],
  input  logic                req_read  [NUM_REQ],
  input  logic                req_write [NUM_REQ],
  input  logic [255:0]        req_wdata [NUM_REQ],
  output logic [255:0]        req_rdata [NUM_REQ],
  output logic                req_resp  [NUM_REQ],
  output logic [31:0]         mem_addr,
  output logic                mem_read,
  output logic                mem_write,
  output logic [255:0]        mem_wdata,
  input  logic [255:0]        mem_rdata,
  input  logic                mem_resp,
  output logic [CNT_W-1:0]    grant_cnt [NUM_REQ],
  output logic                busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        gnt_q, gnt_d;
  logic [GW-1:0]        last_q, last_d;
  logic [NUM_REQ-1:0]   mask_q, mask_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [255:0]         mem_wdata_q, mem_wdata_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic [CNT_W-1:0]     cnt_q [NUM_REQ];
  logic [CNT_W-1:0]     cnt_d [NUM_REQ];

  logic [NUM_REQ-1:0]   valid;
  logic [GW-1:0]        win;
  logic                 win_vld;
  int                   idx;

  // Winner selection; a requester served on the previous edge is masked for one IDLE cycle.
  always_comb begin
    valid   = '0;
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      valid[i] = (req_read[i] | req_write[i]) & ~mask_q[i];
    end
`ifdef DFP_ARB_RR_EN
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_vld && valid[GW'(idx)]) begin
        win_vld = 1'b1;
        win     = GW'(idx);
      end
    end
`else
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i]) begin
        win_vld = 1'b1;
        win     = GW'(i);
      end
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    mask_d      = '0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d     = BUSY;
          gnt_d       = win;
          mem_addr_d  = {req_addr[win][31:5], 5'b0};
          mem_wdata_d = req_wdata[win];
          mem_write_d = req_write[win];
          mem_read_d  = req_read[win] & ~req_write[win];
        end
      end
      BUSY: begin
        if (mem_resp) begin
          state_d        = IDLE;
          mem_read_d     = 1'b0;
          mem_write_d    = 1'b0;
          last_d         = gnt_q;
          mask_d[gnt_q]  = 1'b1;
          if (cnt_q[gnt_q] != {CNT_W{1'b1}}) cnt_d[gnt_q] = cnt_q[gnt_q] + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      last_q      <= GW'(NUM_REQ - 1);
      mask_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      cnt_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      mask_q      <= mask_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      cnt_q       <= cnt_d;
    end
  end

  // Completion is combinational so the cache sees it in the same cycle as mem_resp.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_resp[i]  = (state_q == BUSY) && mem_resp && (gnt_q == GW'(i));
      req_rdata[i] = mem_rdata;
      grant_cnt[i] = cnt_q[i];
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_dfp_arbiter.sv
// Directed bench for dfp_arbiter: expected grants are queued when requests are driven and
// compared when the arbiter issues on the memory port.
module tb_dfp_arbiter;
  localparam int NR = 2;
  localparam int CW = 4;
  localparam logic [255:0] W0  = {8{32'h0BAD_F00D}};
  localparam logic [255:0] W1  = {8{32'hC0DE_1234}};
  localparam logic [255:0] RDA = {32{8'hA5}};
  localparam logic [255:0] RDB = {8{32'h1357_9BDF}};

  logic           clk = 1'b0;
  logic           rst;
  logic [31:0]    req_addr  [NR];
  logic           req_read  [NR];
  logic           req_write [NR];
  logic [255:0]   req_wdata [NR];
  logic [255:0]   req_rdata [NR];
  logic           req_resp  [NR];
  logic [31:0]    mem_addr;
  logic           mem_read, mem_write;
  logic [255:0]   mem_wdata, mem_rdata;
  logic           mem_resp;
  logic [CW-1:0]  grant_cnt [NR];
  logic           busy;

  dfp_arbiter #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_read(req_read), .req_write(req_write),
    .req_wdata(req_wdata), .req_rdata(req_rdata), .req_resp(req_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .grant_cnt(grant_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           idx;
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;
  int   cnt_m [NR];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [31:0] a, input logic wr);
    exp_t e;
    e.idx   = idx;
    e.addr  = a;
    e.wr    = wr;
    e.wdata = (idx == 0) ? W0 : W1;
    exp_q.push_back(e);
  endtask

  task automatic wait_issue(input int exp_wait, output exp_t e);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(mem_read || mem_write) && n < 40);
    chk("issue_latency", n, exp_wait);
    chk("sb_pending", exp_q.size() > 0, 1'b1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      e.idx = 0; e.addr = '0; e.wr = 1'b0; e.wdata = '0;
    end
    chk("mem_addr", mem_addr, e.addr);
    chk("mem_write", mem_write, e.wr);
    chk("mem_read", mem_read, !e.wr);
    chk("mem_wdata", mem_wdata, e.wdata);
    chk("busy_issue", busy, 1'b1);
  endtask

  task automatic serve(input int exp_wait, input int lat, input logic [255:0] rd);
    exp_t e;
    wait_issue(exp_wait, e);
    repeat (lat - 1) begin
      step();
      chk("hold_addr", mem_addr, e.addr);
    end
    mem_rdata = rd;
    mem_resp  = 1'b1;
    #1;
    for (int i = 0; i < NR; i++) chk("req_resp_hi", req_resp[i], i == e.idx);
    chk("req_rdata", req_rdata[e.idx], rd);
    if (cnt_m[e.idx] < 15) cnt_m[e.idx]++;
    step();
    mem_resp = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) begin
      chk("req_resp_lo", req_resp[i], 1'b0);
      chk("grant_cnt", grant_cnt[i], cnt_m[i]);
    end
    chk("busy_after", busy, 1'b0);
    chk("cmd_clear", {mem_read, mem_write}, 2'b00);
  endtask

  initial begin
    rst       = 1'b1;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i]  = '0;
      req_read[i]  = 1'b0;
      req_write[i] = 1'b0;
      cnt_m[i]     = 0;
    end
    req_wdata[0] = W0;
    req_wdata[1] = W1;

    // Reset state
    #12;
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 256'h0);
    chk("rst_busy", busy, 1'b0);
    for (int i = 0; i < NR; i++) begin
      chk("rst_req_resp", req_resp[i], 1'b0);
      chk("rst_grant_cnt", grant_cnt[i], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    step();

    // Single read, then requester 0 holds its request through the masked cycle
    req_read[0] = 1'b1;
    req_addr[0] = 32'h0000_1234;
    push(0, 32'h0000_1220, 1'b0);
    serve(1, 3, RDA);
    step();
    chk("mask_idle_busy", busy, 1'b0);
    chk("mask_idle_read", mem_read, 1'b0);
    push(0, 32'h0000_1220, 1'b0);
    serve(1, 2, RDB);

    // Request held only through the masked cycle: no second issue
    step();
    chk("mask_once_busy", busy, 1'b0);
    req_read[0] = 1'b0;
    repeat (3) begin
      step();
      chk("no_reissue", busy, 1'b0);
    end

    // Simultaneous requests from reset: 0 first, then 1 as a write
    rst = 1'b1;
    for (int i = 0; i < NR; i++) cnt_m[i] = 0;
    @(negedge clk);
    rst = 1'b0;
    step();
    req_read[0]  = 1'b1;
    req_addr[0]  = 32'h0000_2040;
    req_read[1]  = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 32'h0000_305F;
    push(0, 32'h0000_2040, 1'b0);
    push(1, 32'h0000_3040, 1'b1);
    serve(1, 2, RDA);
    req_read[0] = 1'b0;
    serve(1, 2, RDB);
    req_read[1]  = 1'b0;
    req_write[1] = 1'b0;

    // Requester 0 served last; both then request together after idle cycles
    req_read[0] = 1'b1;
    push(0, 32'h0000_2040, 1'b0);
    serve(1, 1, RDA);
    req_read[0] = 1'b0;
    repeat (3) step();
    req_read[0] = 1'b1;
    req_read[1] = 1'b1;
    req_addr[1] = 32'h0000_5000;
`ifdef DFP_ARB_RR_EN
    push(1, 32'h0000_5000, 1'b0);
    push(0, 32'h0000_2040, 1'b0);
    serve(1, 2, RDB);
    req_read[1] = 1'b0;
    serve(1, 2, RDA);
    req_read[0] = 1'b0;
`else
    push(0, 32'h0000_2040, 1'b0);
    push(1, 32'h0000_5000, 1'b0);
    serve(1, 2, RDA);
    req_read[0] = 1'b0;
    serve(1, 2, RDB);
    req_read[1] = 1'b0;
`endif

    // Stale response in IDLE
    step();
    mem_resp = 1'b1;
    #1;
    for (int i = 0; i < NR; i++) chk("stale_resp", req_resp[i], 1'b0);
    step();
    mem_resp = 1'b0;
    #1;
    chk("stale_busy", busy, 1'b0);
    for (int i = 0; i < NR; i++) chk("stale_cnt", grant_cnt[i], cnt_m[i]);

    // Async reset two cycles into BUSY
    begin
      exp_t e;
      req_read[1] = 1'b1;
      req_addr[1] = 32'h0000_6000;
      push(1, 32'h0000_6000, 1'b0);
      wait_issue(1, e);
      repeat (2) step();
      #3;
      rst = 1'b1;
      #1;
      chk("arst_mem_read", mem_read, 1'b0);
      chk("arst_busy", busy, 1'b0);
      for (int i = 0; i < NR; i++) cnt_m[i] = 0;
      for (int i = 0; i < NR; i++) chk("arst_cnt", grant_cnt[i], 0);
      req_read[1] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step();
      mem_resp = 1'b1;
      #1;
      for (int i = 0; i < NR; i++) chk("arst_late_resp", req_resp[i], 1'b0);
      step();
      mem_resp = 1'b0;
      #1;
      chk("arst_late_cnt", grant_cnt[1], 0);
      chk("arst_late_busy", busy, 1'b0);
    end

    // Saturation: 17 transactions on requester 1 with CNT_W = 4
    req_read[1] = 1'b1;
    req_addr[1] = 32'h0000_4000;
    for (int t = 0; t < 17; t++) begin
      push(1, 32'h0000_4000, 1'b0);
      serve((t == 0) ? 1 : 2, 1, RDB);
    end
    req_read[1] = 1'b0;
    step();
    chk("sat_cnt1", grant_cnt[1], 15);
    chk("sat_cnt0", grant_cnt[0], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
